// File: rtl/ad_ip_jesd204_tpl_adc_pn_sweep.sv
// PN-monitor sweep sequencer for the JESD204 TPL ADC channels.
// Steps every channel through a list of PN sequences, lets the monitors
// settle, watches pn_oos/pn_err for a dwell window and records pass/fail.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no sweep; pn_seq_sel parked at IDLE_SEL, waiting for start
// ST_APPLY  | load the current sequence onto enabled channels (1 cycle)
// ST_SETTLE | monitors resynchronise; status inputs ignored
// ST_DWELL  | accumulate per-channel failures
// ST_RECORD | write pass bits for the current sequence (1 cycle)
// ST_DONE   | sweep finished, done pulse (1 cycle)
module ad_ip_jesd204_tpl_adc_pn_sweep #(
    parameter int          NUM_CHANNELS  = 4,
    parameter int          NUM_SEQS      = 2,
    parameter logic [31:0] SEQ_LIST      = 32'h0000_0010,
    parameter logic [3:0]  IDLE_SEL      = 4'h0,
    parameter int          SETTLE_CYCLES = 64,
    parameter int          DWELL_CYCLES  = 1024
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             start,
    input  logic                             abort,
    input  logic [NUM_CHANNELS-1:0]          ch_enable,
    output logic [4*NUM_CHANNELS-1:0]        pn_seq_sel,
    input  logic [NUM_CHANNELS-1:0]          pn_oos,
    input  logic [NUM_CHANNELS-1:0]          pn_err,
    output logic                             busy,
    output logic                             done,
    output logic                             aborted,
    output logic [2:0]                       seq_idx,
    output logic [NUM_SEQS*NUM_CHANNELS-1:0] result_pass,
    output logic                             fail_any
);

    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int DW_W  = $clog2(DWELL_CYCLES) + 1;
    localparam logic [4*NUM_CHANNELS-1:0] IDLE_ALL = {NUM_CHANNELS{IDLE_SEL}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_DWELL,
        ST_RECORD,
        ST_DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [SET_W-1:0]          settle_cnt;
    logic [DW_W-1:0]           dwell_cnt;
    logic [NUM_CHANNELS-1:0]   en;
    logic [NUM_CHANNELS-1:0]   fail;
    logic [4*NUM_CHANNELS-1:0] apply_sel;
    logic                      last_seq;
    logic                      start_go;
    logic                      record_go;
    logic                      abort_go;

    assign last_seq  = (seq_idx == 3'(NUM_SEQS - 1));
    assign start_go  = (state == ST_IDLE) && start && !abort;
    assign abort_go  = (state != ST_IDLE) && abort;
    assign record_go = (state == ST_RECORD) && !abort;

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // next-state decode; abort overrides everything outside IDLE
    always_comb begin
        state_nxt = state;
        if (abort_go) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start_go) state_nxt = ST_APPLY;
                ST_APPLY:  state_nxt = ST_SETTLE;
                ST_SETTLE: if (settle_cnt == '0) state_nxt = ST_DWELL;
                ST_DWELL:  if (dwell_cnt == '0) state_nxt = ST_RECORD;
                ST_RECORD: state_nxt = last_seq ? ST_DONE : ST_APPLY;
                ST_DONE:   state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // per-channel select for the sequence about to be applied
    always_comb begin
        apply_sel = IDLE_ALL;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (en[c]) apply_sel[4*c +: 4] = SEQ_LIST[4*int'(seq_idx) +: 4];
        end
    end

    // settle and dwell down-counters, each reloaded as its window opens
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            settle_cnt <= '0;
            dwell_cnt  <= '0;
        end else begin
            case (state)
                ST_APPLY: settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
                ST_SETTLE: begin
                    if (settle_cnt == '0) dwell_cnt <= DW_W'(DWELL_CYCLES - 1);
                    else                  settle_cnt <= settle_cnt - SET_W'(1);
                end
                ST_DWELL: if (dwell_cnt != '0) dwell_cnt <= dwell_cnt - DW_W'(1);
                default: ;
            endcase
        end
    end

    // enable latch, failure accumulation and result matrix
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en          <= '0;
            fail        <= '0;
            seq_idx     <= '0;
            result_pass <= '0;
            fail_any    <= 1'b0;
        end else begin
            if (start_go) begin
                en          <= ch_enable;
                seq_idx     <= '0;
                result_pass <= '0;
                fail_any    <= 1'b0;
            end
            if (state == ST_APPLY) fail <= '0;
            if (state == ST_DWELL) fail <= fail | ((pn_oos | pn_err) & en);
            if (record_go) begin
                result_pass[int'(seq_idx)*NUM_CHANNELS +: NUM_CHANNELS] <= en & ~fail;
                fail_any <= fail_any | (|fail);
                if (!last_seq) seq_idx <= seq_idx + 3'd1;
            end
        end
    end

    // registered status outputs and channel selects, aligned to the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            pn_seq_sel <= IDLE_ALL;
        end else begin
            busy    <= (state_nxt != ST_IDLE);
            done    <= (state_nxt == ST_DONE);
            aborted <= abort_go;
            if (state_nxt == ST_IDLE || state_nxt == ST_DONE) pn_seq_sel <= IDLE_ALL;
            else if (state == ST_APPLY)                         pn_seq_sel <= apply_sel;
        end
    end

endmodule

// File: doc/ad_ip_jesd204_tpl_adc_pn_sweep.md
Name: ad_ip_jesd204_tpl_adc_pn_sweep

Overview:
- Sequences PN-monitor self-test across all converter channels of the JESD204 TPL ADC.
- Drives each channel's pn_seq_sel from a programmed sequence list, waits a settle window, then observes pn_oos/pn_err over a dwell window.
- Records a pass/fail matrix per sequence per channel.
- Sits between the up_adc register/control layer and the per-channel datapaths, in the same clock domain as the channel PN monitors.

Parameters:
- NUM_CHANNELS, 4, number of converter channels swept in parallel.
- NUM_SEQS, 2, number of sequences in SEQ_LIST (1..8).
- SEQ_LIST, 32'h0000_0010, packed 4-bit pn_seq_sel codes; entry i = SEQ_LIST[4*i+:4].
- IDLE_SEL, 4'h0, pn_seq_sel code driven while not sweeping.
- SETTLE_CYCLES, 64, cycles after a sequence change before checking (>=1).
- DWELL_CYCLES, 1024, observation cycles per sequence (>=1).

Ports:
- clk  input  1  core/link clock shared with the channel datapaths.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle sweep request; honoured only in IDLE.
- abort  input  1  terminates a sweep from any state.
- ch_enable  input  NUM_CHANNELS  per-channel participation mask, sampled at start.
- pn_seq_sel  output  4*NUM_CHANNELS  per-channel sequence select; channel c = [4*c+:4].
- pn_oos  input  NUM_CHANNELS  per-channel out-of-sync status.
- pn_err  input  NUM_CHANNELS  per-channel error status.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a sweep completes.
- aborted  output  1  one-cycle pulse when a sweep is aborted.
- seq_idx  output  3  index of the sequence currently applied.
- result_pass  output  NUM_SEQS*NUM_CHANNELS  bit [i*NUM_CHANNELS+c] = channel c passed sequence i.
- fail_any  output  1  OR of failures over enabled channels of all recorded sequences.

Behaviour:
- Reset values:
  - pn_seq_sel = IDLE_SEL replicated on every channel.
  - busy, done, aborted = 0; seq_idx = 0; result_pass = 0; fail_any = 0.
  - State = IDLE; counters = 0; latched enable mask = 0.
- All outputs are registered. Counters are sized to clog2 of their respective cycle parameter plus 1.
- States: IDLE, APPLY, SETTLE, DWELL, RECORD, DONE.
- IDLE:
  - On start=1 and abort=0: latch ch_enable, clear result_pass and fail_any, set seq_idx=0, go to APPLY.
  - start and abort in the same cycle: abort wins; stay in IDLE with no pulse.
- APPLY (1 cycle):
  - Register pn_seq_sel[c] = SEQ_LIST[seq_idx] for each enabled channel; disabled channels get IDLE_SEL.
  - Clear per-channel fail latches.
  - Go to SETTLE.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles; pn_oos and pn_err are ignored.
  - Go to DWELL.
- DWELL:
  - Lasts exactly DWELL_CYCLES cycles.
  - Each cycle: fail[c] |= (pn_oos[c] | pn_err[c]) & en[c].
- RECORD (1 cycle):
  - result_pass[seq_idx*NUM_CHANNELS+c] = en[c] & ~fail[c].
  - fail_any |= |fail.
  - If seq_idx == NUM_SEQS-1, go to DONE; else increment seq_idx and go to APPLY.
- DONE (1 cycle):
  - done=1; pn_seq_sel returns to IDLE_SEL on all channels.
  - Go to IDLE. seq_idx holds its last value; results hold until the next start.
- Timing: with start sampled at cycle 0, APPLY is at cycle 1 and each sequence takes SETTLE_CYCLES+DWELL_CYCLES+2 cycles. DONE, with done high, is at cycle 1+NUM_SEQS*(SETTLE_CYCLES+DWELL_CYCLES+2).
- abort in any non-IDLE state:
  - Next cycle: state IDLE, aborted=1 for one cycle, pn_seq_sel = IDLE_SEL.
  - No done pulse. Results of already-RECORDed sequences are retained; the partially observed sequence is not written.
- start while busy is ignored. ch_enable changes mid-sweep have no effect.
- All channels disabled: the sweep still runs full length; result_pass stays all-zero and fail_any stays 0.
- Asynchronous reset mid-sweep: immediate return to the reset values above.

Test Plan:
- Nominal pass (NUM_SEQS=2, S=4, D=8, ch_enable=4'hf, pn_oos=pn_err=0, start at cycle 0):
  - pn_seq_sel = 16'h0000 from cycle 2, then 16'h1111 after the first RECORD.
  - done pulse at cycle 29; result_pass = 8'hff; fail_any = 0; busy high for cycles 1-29.
- Settle masking: pn_oos[2]=1 only during SETTLE of sequence 0 -> result_pass = 8'hff.
- Dwell error: a single-cycle pn_err[1] in the last DWELL cycle of sequence 1 -> result_pass = 8'hdf; fail_any = 1.
- Enable mask: ch_enable = 4'b0101 with pn_err[1]=1 throughout -> channels 1 and 3 get pn_seq_sel = IDLE_SEL; result_pass = 8'h55; fail_any = 0.
- Abort during DWELL of sequence 1:
  - aborted pulses the next cycle; busy drops; pn_seq_sel = IDLE_SEL; no done pulse.
  - result_pass[3:0] keeps sequence 0's recorded value; result_pass[7:4] = 0.
- Contention and reset:
  - start+abort in IDLE -> stays IDLE, no pulses.
  - start during SETTLE -> ignored, done timing unchanged.
  - resetn low mid-DWELL -> all outputs immediately return to their reset values.
